// File: rtl/exe_stage_if.sv
// Operand/control bundle entering the execute stage and the EX/MEM results leaving it.
// slave: the execute stage itself; master: whatever drives it (decode side / bench).
interface exe_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [3:0]        exe_cmd;
    logic              s_bit;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] st_val;
    logic [3:0]        dest;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] pc;
    logic [23:0]       imm24;
    logic              branch_in;

    logic [DATA_W-1:0] alu_res_out;
    logic [DATA_W-1:0] st_val_out;
    logic [3:0]        dest_out;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              valid_out;
    logic [3:0]        status;
    logic [DATA_W-1:0] branch_addr;
    logic              branch_taken;

    modport master (
        output in_valid, exe_cmd, s_bit, val1, val2, st_val, dest,
               wb_en, mem_r_en, mem_w_en, pc, imm24, branch_in,
        input  alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, valid_out, status, branch_addr, branch_taken
    );

    modport slave (
        input  in_valid, exe_cmd, s_bit, val1, val2, st_val, dest,
               wb_en, mem_r_en, mem_w_en, pc, imm24, branch_in,
        output alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, valid_out, status, branch_addr, branch_taken
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: ALU + NZCV status register + branch target, feeding the EX/MEM register.
// Latency: 1 cycle to EX/MEM outputs and status; branch_addr/branch_taken are combinational.
// Backpressure: freeze holds EX/MEM and status; flush loads a bubble and wins over freeze.
module exe_stage #(
    parameter int         DATA_W     = 32,
    parameter logic [3:0] STATUS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       flush,
    exe_stage_if.slave bus
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [3:0]        status_q;
    logic [DATA_W-1:0] res;
    logic [DATA_W:0]   sum;
    logic              c_new;
    logic              v_new;
    logic              c_in;
    logic              a_msb;
    logic              b_msb;

    assign c_in  = status_q[1];
    assign a_msb = bus.val1[DATA_W-1];
    assign b_msb = bus.val2[DATA_W-1];

    // C and V default to the current flags so logical/move ops leave them untouched.
    always_comb begin
        sum   = '0;
        res   = '0;
        c_new = status_q[1];
        v_new = status_q[0];
        case (bus.exe_cmd)
            CMD_MOV: res = bus.val2;
            CMD_MVN: res = ~bus.val2;
            CMD_ADD, CMD_ADC: begin
                sum   = {1'b0, bus.val1} + {1'b0, bus.val2}
                      + {{DATA_W{1'b0}}, (bus.exe_cmd == CMD_ADC) & c_in};
                res   = sum[DATA_W-1:0];
                c_new = sum[DATA_W];
                v_new = (a_msb == b_msb) && (res[DATA_W-1] != a_msb);
            end
            CMD_SUB, CMD_SBC: begin
                // A wrap into bit DATA_W means a borrow; C is the ARM-style not-borrow.
                sum   = {1'b0, bus.val1} - {1'b0, bus.val2}
                      - {{DATA_W{1'b0}}, (bus.exe_cmd == CMD_SBC) & ~c_in};
                res   = sum[DATA_W-1:0];
                c_new = ~sum[DATA_W];
                v_new = (a_msb != b_msb) && (res[DATA_W-1] != a_msb);
            end
            CMD_AND: res = bus.val1 & bus.val2;
            CMD_ORR: res = bus.val1 | bus.val2;
            CMD_EOR: res = bus.val1 ^ bus.val2;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.alu_res_out  <= '0;
            bus.st_val_out   <= '0;
            bus.dest_out     <= '0;
            bus.wb_en_out    <= 1'b0;
            bus.mem_r_en_out <= 1'b0;
            bus.mem_w_en_out <= 1'b0;
            bus.valid_out    <= 1'b0;
            status_q         <= STATUS_RST;
        end else begin
            if (flush) begin
                bus.alu_res_out  <= '0;
                bus.st_val_out   <= '0;
                bus.dest_out     <= '0;
                bus.wb_en_out    <= 1'b0;
                bus.mem_r_en_out <= 1'b0;
                bus.mem_w_en_out <= 1'b0;
                bus.valid_out    <= 1'b0;
            end else if (!freeze) begin
                bus.alu_res_out  <= res;
                bus.st_val_out   <= bus.st_val;
                bus.dest_out     <= bus.dest;
                bus.wb_en_out    <= bus.wb_en & bus.in_valid;
                bus.mem_r_en_out <= bus.mem_r_en & bus.in_valid;
                bus.mem_w_en_out <= bus.mem_w_en & bus.in_valid;
                bus.valid_out    <= bus.in_valid;
            end
            if (bus.in_valid && bus.s_bit && !flush && !freeze) begin
                status_q <= {res[DATA_W-1], (res == '0), c_new, v_new};
            end
        end
    end

    assign bus.status       = status_q;
    assign bus.branch_addr  = bus.pc + {{(DATA_W-26){bus.imm24[23]}}, bus.imm24, 2'b00};
    assign bus.branch_taken = bus.branch_in & bus.in_valid & ~flush;
endmodule

// File: tb/tb_exe_stage.sv
// Randomized and directed bench for exe_stage, checked against an arithmetic reference model.
module tb_exe_stage;
    logic clk = 1'b0;
    logic rst;
    logic freeze;
    logic flush;

    always #5 clk = ~clk;

    exe_stage_if #(.DATA_W(32)) bus();

    exe_stage #(.DATA_W(32), .STATUS_RST(4'b0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .flush  (flush),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expected EX/MEM contents and status.
    logic [31:0] m_res, m_st;
    logic [3:0]  m_dest, m_status;
    logic        m_wb, m_mr, m_mw, m_vld;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Result and flags from plain integer arithmetic; overflow is judged by signed range.
    function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] a,
                                      input logic [31:0] b, input logic [3:0] st,
                                      output logic [31:0] res, output logic [3:0] nst);
        longint unsigned ua, ub, cin, borrow;
        longint sa, sb, sr;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = longint'(st[1]);
        borrow = 64'd1 - cin;
        c = st[1];
        v = st[0];
        res = 32'd0;
        sr = 0;
        case (cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                if (cmd == 4'd2) cin = 0;
                res = 32'(ua + ub + cin);
                c = (ua + ub + cin) >= 64'h1_0000_0000;
                sr = sa + sb + longint'(cin);
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                if (cmd == 4'd4) borrow = 0;
                res = 32'(ua - ub - borrow);
                c = ua >= ub + borrow;
                sr = sa - sb - longint'(borrow);
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            default: res = 32'd0;
        endcase
        nst = {res[31], res == 32'd0, c, v};
    endfunction

    task automatic compare_all();
        check("alu_res_out", bus.alu_res_out, m_res);
        check("st_val_out", bus.st_val_out, m_st);
        check("dest_out", {28'd0, bus.dest_out}, {28'd0, m_dest});
        check("wb_en_out", {31'd0, bus.wb_en_out}, {31'd0, m_wb});
        check("mem_r_en_out", {31'd0, bus.mem_r_en_out}, {31'd0, m_mr});
        check("mem_w_en_out", {31'd0, bus.mem_w_en_out}, {31'd0, m_mw});
        check("valid_out", {31'd0, bus.valid_out}, {31'd0, m_vld});
        check("status", {28'd0, bus.status}, {28'd0, m_status});
    endtask

    // One clock: check combinational outputs, predict, clock, compare registered outputs.
    task automatic step();
        logic [31:0] r;
        logic [3:0]  ns;
        longint      off;
        #1;
        off = bus.imm24[23] ? longint'(bus.imm24) - 64'sd16777216 : longint'(bus.imm24);
        check("branch_addr", bus.branch_addr, 32'(longint'(bus.pc) + off * 4));
        check("branch_taken", {31'd0, bus.branch_taken},
              {31'd0, bus.branch_in & bus.in_valid & ~flush});
        model_alu(bus.exe_cmd, bus.val1, bus.val2, m_status, r, ns);
        if (!rst) begin
            {m_res, m_st, m_dest, m_wb, m_mr, m_mw, m_vld} = '0;
            m_status = 4'b0000;
        end else begin
            if (flush) begin
                {m_res, m_st, m_dest, m_wb, m_mr, m_mw, m_vld} = '0;
            end else if (!freeze) begin
                m_res  = r;
                m_st   = bus.st_val;
                m_dest = bus.dest;
                m_wb   = bus.wb_en & bus.in_valid;
                m_mr   = bus.mem_r_en & bus.in_valid;
                m_mw   = bus.mem_w_en & bus.in_valid;
                m_vld  = bus.in_valid;
            end
            if (bus.in_valid && bus.s_bit && !flush && !freeze) m_status = ns;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2: return 32'h7FFF_FFFF + 32'($urandom_range(0, 3));
            default: return 32'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic rand_side();
        bus.st_val    = $urandom;
        bus.dest      = 4'($urandom_range(0, 15));
        bus.wb_en     = 1'($urandom_range(0, 1));
        bus.mem_r_en  = 1'($urandom_range(0, 1));
        bus.mem_w_en  = 1'($urandom_range(0, 1));
        bus.pc        = $urandom;
        bus.imm24     = 24'($urandom);
        bus.branch_in = 1'($urandom_range(0, 1));
    endtask

    task automatic setop(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        rand_side();
        bus.in_valid = 1'b1;
        bus.exe_cmd  = cmd;
        bus.s_bit    = s;
        bus.val1     = a;
        bus.val2     = b;
    endtask

    initial begin
        {m_res, m_st, m_dest, m_wb, m_mr, m_mw, m_vld, m_status} = '0;
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        setop(4'd2, 1'b1, 32'd1, 32'd2);
        rst = 1'b0;
        step();
        step();
        check("reset alu_res_out", bus.alu_res_out, 32'd0);
        check("reset valid_out", {31'd0, bus.valid_out}, 32'd0);
        check("reset status", {28'd0, bus.status}, 32'd0);

        setop(4'd2, 1'b1, 32'hFFFF_FFFF, 32'h1); step();
        check("add carry res", bus.alu_res_out, 32'h0);
        check("add carry status", {28'd0, bus.status}, 32'b0110);
        setop(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h1); step();
        check("add ovf res", bus.alu_res_out, 32'h8000_0000);
        check("add ovf status", {28'd0, bus.status}, 32'b1001);
        setop(4'd4, 1'b1, 32'd5, 32'd7); step();
        check("sub borrow res", bus.alu_res_out, 32'hFFFF_FFFE);
        check("sub borrow status", {28'd0, bus.status}, 32'b1000);

        setop(4'd2, 1'b1, 32'hFFFF_FFFF, 32'h1); step();
        setop(4'd3, 1'b1, 32'd1, 32'd1); step();
        check("adc res", bus.alu_res_out, 32'd3);
        check("adc status", {28'd0, bus.status}, 32'b0000);
        setop(4'd5, 1'b1, 32'd5, 32'd2); step();
        check("sbc res", bus.alu_res_out, 32'd2);
        check("sbc status", {28'd0, bus.status}, 32'b0010);

        setop(4'd2, 1'b1, 32'h8000_0000, 32'h8000_0000); step();
        check("set cv status", {28'd0, bus.status}, 32'b0111);
        setop(4'd6, 1'b1, 32'hF0, 32'h0F); step();
        check("and res", bus.alu_res_out, 32'd0);
        check("and keeps cv", {28'd0, bus.status}, 32'b0111);

        for (int i = 0; i < 3; i++) begin
            setop(4'($urandom_range(1, 9)), 1'b1, $urandom, $urandom);
            freeze = 1'b1;
            step();
            check("freeze res", bus.alu_res_out, 32'd0);
            check("freeze status", {28'd0, bus.status}, 32'b0111);
            check("freeze valid", {31'd0, bus.valid_out}, 32'd1);
        end
        setop(4'd2, 1'b1, 32'd9, 32'd9);
        bus.wb_en = 1'b1;
        freeze = 1'b1; flush = 1'b1;
        step();
        check("flush+freeze valid", {31'd0, bus.valid_out}, 32'd0);
        check("flush+freeze wb_en", {31'd0, bus.wb_en_out}, 32'd0);
        check("flush+freeze status", {28'd0, bus.status}, 32'b0111);

        setop(4'd0, 1'b0, 32'd0, 32'd0);
        bus.pc = 32'h100; bus.imm24 = 24'hFF_FFFE; bus.branch_in = 1'b1;
        #1;
        check("branch addr lit", bus.branch_addr, 32'hF8);
        check("branch taken lit", {31'd0, bus.branch_taken}, 32'd1);
        flush = 1'b1;
        #1;
        check("branch flushed lit", {31'd0, bus.branch_taken}, 32'd0);
        step();

        for (int i = 0; i < 1500; i++) begin
            setop(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_val(), rand_val());
            bus.in_valid = ($urandom_range(0, 4) != 0);
            freeze = ($urandom_range(0, 4) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            rst    = ($urandom_range(0, 99) != 0);
            step();
        end

        setop(4'd2, 1'b1, 32'd3, 32'd4);
        bus.wb_en = 1'b1;
        step();
        check("pre-reset res", bus.alu_res_out, 32'd7);
        setop(4'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rst = 1'b0;
        step();
        check("midreset res", bus.alu_res_out, 32'd0);
        check("midreset wb_en", {31'd0, bus.wb_en_out}, 32'd0);
        check("midreset valid", {31'd0, bus.valid_out}, 32'd0);
        check("midreset status", {28'd0, bus.status}, 32'd0);
        setop(4'd3, 1'b1, 32'd1, 32'd1); step();
        check("post-reset adc", bus.alu_res_out, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
